// File: rtl/result_reader_pkg.sv
// Shared constants, state encoding and FIFO entry layout for result_reader.
package result_reader_pkg;

  localparam int RES_PER_MAT = 16;
  localparam int MAX_MAT     = 8;

  // Tag bits stored under the data word in each FIFO entry.
  localparam int TAG_W    = 8;
  localparam int COL_LSB  = 0;
  localparam int ROW_LSB  = 2;
  localparam int MAT_LSB  = 4;
  localparam int LAST_BIT = 7;

  typedef enum logic [2:0] {IDLE, WAIT, STREAM, DRAIN, FIN} state_t;

  // Number of results to drain for a requested matrix count, clamped to MAX_MAT.
  function automatic logic [7:0] total_for(input logic [3:0] n);
    logic [3:0] c;
    c = (n > 4'(MAX_MAT)) ? 4'(MAX_MAT) : n;
    return 8'(c) * 8'(RES_PER_MAT);
  endfunction

endpackage

// File: rtl/result_reader_fifo.sv
// Small first-word-fall-through FIFO holding captured result beats.
module result_fifo #(
  parameter int W     = 40,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr, rd;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd];

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of 2).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr    <= '0;
      rd    <= '0;
      count <= '0;
    end else begin
      if (do_push) wr <= wr + PW'(1);
      if (do_pop)  rd <= rd + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage write; contents need no reset since empty gates the head.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr] <= wdata;
  end

endmodule

// File: rtl/result_reader.sv
// Drains the systolic-array output memory after ap_done and streams each
// result as a tagged valid/ready beat, in strict address order.
module result_reader
  import result_reader_pkg::*;
#(
  parameter int AW    = 7,
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [3:0]    num_mat,
  input  logic          ap_done,
  output logic [AW-1:0] addrO,
  input  logic [DW-1:0] dataO,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic [2:0]    m_mat,
  output logic [1:0]    m_row,
  output logic [1:0]    m_col,
  output logic          m_last,
  output logic          busy,
  output logic          done
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = DW + TAG_W;

  state_t          state, state_nxt;
  logic [AW:0]     total, total_in, cnt;
  logic            inflight;
  logic            issue, last_issue, pop, push, drained;
  logic [CW-1:0]   count;
  logic [CW:0]     occ;
  logic            empty, full;
  logic [EW-1:0]   push_data, head;
  logic            push_last;

  assign total_in   = (AW+1)'(total_for(num_mat));
  assign pop        = m_valid && m_ready;
  // Entries that will be held after this cycle if nothing new is issued;
  // issuing only below DEPTH means the FIFO can never overflow.
  assign occ        = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign issue      = (state == STREAM) && (occ < (CW+1)'(DEPTH));
  assign last_issue = (cnt == total - (AW+1)'(1));
  // Empty after this cycle's pop with nothing left in flight.
  assign drained    = !inflight && (empty || (count == CW'(1) && pop));

  // The read word for the address issued last cycle arrives now; addrO still
  // holds that address, so it doubles as the tag.
  assign push_last  = ({1'b0, addrO} == total - (AW+1)'(1));
  assign push       = inflight && !full;
  assign push_data  = {dataO, push_last, addrO[6:0]};

  result_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (push_data),
    .rdata (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  assign m_valid = !empty;
  assign m_data  = empty ? '0 : head[TAG_W +: DW];
  assign m_last  = !empty && head[LAST_BIT];
  assign m_mat   = empty ? '0 : head[MAT_LSB +: 3];
  assign m_row   = empty ? '0 : head[ROW_LSB +: 2];
  assign m_col   = empty ? '0 : head[COL_LSB +: 2];
  assign busy    = (state != IDLE);
  assign done    = (state == FIN);

  // State register plus address counter, issue register and in-flight flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      total    <= '0;
      cnt      <= '0;
      addrO    <= '0;
      inflight <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= issue;
      if (state == IDLE) begin
        cnt   <= '0;
        addrO <= '0;
        if (start) total <= total_in;
      end else if (state == FIN) begin
        addrO <= '0;
      end else if (issue) begin
        addrO <= cnt[AW-1:0];
        cnt   <= cnt + (AW+1)'(1);
      end
    end
  end

  // Next-state logic for the drain sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (total_in == '0) ? FIN : WAIT;
      WAIT:    if (ap_done) state_nxt = STREAM;
      STREAM:  if (issue && last_issue) state_nxt = DRAIN;
      DRAIN:   if (drained) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule
